mmio_int_ctrl: RTL and testbench



---
 rtl/io_map_pkg.sv | 31 +++
 rtl/prio_enc.sv | 21 ++
 rtl/mmio_int_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mmio_int_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_map_pkg.sv
// Shared I/O map for the computer top level: peripheral addresses, interrupt controller
// register offsets and controller state encoding.
package io_map_pkg;

    localparam logic [7:0] IO_BASE   = 8'd248;
    localparam logic [7:0] IO_LAST   = 8'd255;
    localparam logic [7:0] INTC_BASE = 8'd240;

    localparam logic [2:0] OFF_ENABLE  = 3'd0;
    localparam logic [2:0] OFF_PENDING = 3'd1;
    localparam logic [2:0] OFF_VBASE   = 3'd2;
    localparam logic [2:0] OFF_CAUSE   = 3'd3;
    localparam logic [2:0] OFF_EOI     = 3'd4;
    localparam logic [2:0] OFF_MODE    = 3'd5;
    localparam int unsigned NUM_REGS   = 6;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StService = 2'd2
    } intc_state_e;

    // Handler address for a source id; wraps at 8 bits.
    function automatic logic [7:0] vec_addr(input logic [7:0] base, input logic [2:0] id,
                                            input int unsigned shift);
        logic [7:0] stride;
        stride = {5'b0, id} << shift;
        return base + stride;
    endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-wins priority encoder; index 0 has the highest priority.
module prio_enc #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] req,
    output logic         found,
    output logic [2:0]   idx
);

    always_comb begin
        found = 1'b0;
        idx   = 3'd0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = 3'(i);
            end
        end
    end

endmodule

// File: rtl/mmio_int_ctrl.sv
// Memory-mapped interrupt controller: latches peripheral requests, presents one prioritised
// request and vector to the CPU, and tracks it through acknowledge and end-of-interrupt.
module mmio_int_ctrl
    import io_map_pkg::*;
#(
    parameter int unsigned N_SRC     = 4,
    parameter logic [7:0]  BASE_ADDR = INTC_BASE,
    parameter int unsigned VEC_SHIFT = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [7:0]       addr,
    input  logic [7:0]       w_data,
    input  logic             w_en,
    output logic [7:0]       r_data,
    output logic             hit,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             int_ack,
    output logic             int_req,
    output logic [7:0]       int_vec,
    output logic [7:0]       int_en
);

    intc_state_e      state_q;
    logic [2:0]       id_q;
    logic [7:0]       vbase_q;
    logic [N_SRC-1:0] enable_q, pending_q, mode_q, prev_src_q;
    logic [N_SRC-1:0] enable_d, pending_d, set_mask, ack_mask, clr_mask, wdata_src;
    logic [N_SRC-1:0] eligible_q, eligible_d;
    logic [7:0]       offset;
    logic             reg_wr, wr_enable, wr_pending, wr_vbase, wr_mode, eoi_wr, ack_take;
    logic             cur_found, nxt_found;
    logic [2:0]       cur_idx, nxt_idx;

    // 9-bit compare so a base near the top of the map cannot wrap into low addresses.
    assign hit    = ({1'b0, addr} >= {1'b0, BASE_ADDR}) &&
                    ({1'b0, addr} <= ({1'b0, BASE_ADDR} + 9'd5));
    assign offset = addr - BASE_ADDR;
    assign reg_wr = w_en && hit;

    assign wr_enable  = reg_wr && (offset == {5'b0, OFF_ENABLE});
    assign wr_pending = reg_wr && (offset == {5'b0, OFF_PENDING});
    assign wr_vbase   = reg_wr && (offset == {5'b0, OFF_VBASE});
    assign wr_mode    = reg_wr && (offset == {5'b0, OFF_MODE});
    assign eoi_wr     = reg_wr && (offset == {5'b0, OFF_EOI}) && (state_q == StService);
    assign ack_take   = (state_q == StReq) && int_ack;
    assign wdata_src  = w_data[N_SRC-1:0];

    always_comb begin
        // Edge-mode bits only set on a rising input; level-mode bits set whenever high.
        set_mask = irq_src & ~(mode_q & prev_src_q);
        ack_mask = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (ack_take && (id_q == 3'(i))) begin
                ack_mask[i] = 1'b1;
            end
        end
        clr_mask  = ack_mask | (wr_pending ? wdata_src : '0);
        pending_d = (pending_q & ~clr_mask) | set_mask;
        enable_d  = wr_enable ? wdata_src : enable_q;
    end

    assign eligible_q = pending_q & enable_q;
    assign eligible_d = pending_d & enable_d;

    prio_enc #(.N(N_SRC)) u_prio_cur (
        .req   (eligible_q),
        .found (cur_found),
        .idx   (cur_idx)
    );

    prio_enc #(.N(N_SRC)) u_prio_nxt (
        .req   (eligible_d),
        .found (nxt_found),
        .idx   (nxt_idx)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            enable_q   <= '0;
            pending_q  <= '0;
            mode_q     <= '0;
            prev_src_q <= '0;
            vbase_q    <= 8'h00;
        end else begin
            enable_q   <= enable_d;
            pending_q  <= pending_d;
            prev_src_q <= irq_src;
            if (wr_vbase) begin
                vbase_q <= w_data;
            end
            if (wr_mode) begin
                mode_q <= wdata_src;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= StIdle;
            id_q    <= 3'd0;
            int_vec <= 8'h00;
            int_req <= 1'b0;
            int_en  <= 8'h01;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cur_found) begin
                        state_q <= StReq;
                        id_q    <= cur_idx;
                        int_vec <= vec_addr(vbase_q, cur_idx, VEC_SHIFT);
                        int_req <= 1'b1;
                    end
                end
                StReq: begin
                    // Ack wins over a simultaneous withdrawal and keeps the latched id.
                    if (int_ack) begin
                        state_q <= StService;
                        int_req <= 1'b0;
                        int_en  <= 8'h00;
                    end else if (!nxt_found) begin
                        state_q <= StIdle;
                        int_req <= 1'b0;
                    end else begin
                        id_q    <= nxt_idx;
                        int_vec <= vec_addr(vbase_q, nxt_idx, VEC_SHIFT);
                    end
                end
                StService: begin
                    if (eoi_wr) begin
                        state_q <= StIdle;
                        int_en  <= 8'h01;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    int_req <= 1'b0;
                    int_en  <= 8'h01;
                end
            endcase
        end
    end

    logic [7:0] enable_rd, pending_rd, mode_rd;
    logic       cause_valid;

    assign cause_valid = (state_q != StIdle);

    always_comb begin
        enable_rd  = '0;
        pending_rd = '0;
        mode_rd    = '0;
        enable_rd[N_SRC-1:0]  = enable_q;
        pending_rd[N_SRC-1:0] = pending_q;
        mode_rd[N_SRC-1:0]    = mode_q;
        r_data = 8'h00;
        if (hit) begin
            case (offset[2:0])
                OFF_ENABLE:  r_data = enable_rd;
                OFF_PENDING: r_data = pending_rd;
                OFF_VBASE:   r_data = vbase_q;
                OFF_CAUSE:   r_data = {cause_valid, 4'b0, id_q};
                OFF_MODE:    r_data = mode_rd;
                default:     r_data = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_int_ctrl.sv
// Bench for mmio_int_ctrl: directed scenarios with literal expectations, then randomized
// traffic, all compared every cycle against a behavioural model.
module tb_mmio_int_ctrl;

    localparam int N = 4;
    localparam logic [7:0] BASE = 8'd240;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [7:0]   addr, w_data, r_data, int_vec, int_en;
    logic         w_en, hit, int_ack, int_req;
    logic [N-1:0] irq_src;

    int errors = 0;
    int checks = 0;

    mmio_int_ctrl #(
        .N_SRC     (N),
        .BASE_ADDR (BASE),
        .VEC_SHIFT (2)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .addr    (addr),
        .w_data  (w_data),
        .w_en    (w_en),
        .r_data  (r_data),
        .hit     (hit),
        .irq_src (irq_src),
        .int_ack (int_ack),
        .int_req (int_req),
        .int_vec (int_vec),
        .int_en  (int_en)
    );

    always #5 clock = ~clock;

    // Model state: plain bit arrays plus two flags for "asking" and "being serviced".
    logic [7:0] m_en, m_pend, m_mode, m_prev, m_vbase, m_vec;
    int         m_id;
    bit         m_asking, m_serving;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit in_win(input logic [7:0] a);
        return (int'(a) >= int'(BASE)) && (int'(a) <= int'(BASE) + 5);
    endfunction

    function automatic int lowest(input logic [7:0] m);
        for (int i = 0; i < N; i++) begin
            if (m[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] a);
        logic [7:0] v;
        v = 8'h00;
        if (in_win(a)) begin
            case (int'(a) - int'(BASE))
                0: v = m_en;
                1: v = m_pend;
                2: v = m_vbase;
                3: v = {(m_asking || m_serving), 4'b0, 3'(m_id)};
                5: v = m_mode;
                default: v = 8'h00;
            endcase
        end
        return v;
    endfunction

    task automatic model_step();
        int         off, w;
        bit         wr;
        logic [7:0] np, ne, mask;
        if (!reset_n) begin
            m_en = 0; m_pend = 0; m_mode = 0; m_prev = 0; m_vbase = 0; m_vec = 0;
            m_id = 0; m_asking = 0; m_serving = 0;
            return;
        end
        mask = 8'((1 << N) - 1);
        off  = int'(addr) - int'(BASE);
        wr   = w_en && in_win(addr);
        np   = 8'h00;
        for (int i = 0; i < N; i++) begin
            bit rising, keep;
            rising = irq_src[i] && !(m_mode[i] && m_prev[i]);
            keep   = m_pend[i] && !(wr && off == 1 && w_data[i])
                     && !(m_asking && int_ack && m_id == i);
            np[i]  = rising || keep;
        end
        ne = (wr && off == 0) ? (w_data & mask) : m_en;
        if (m_asking) begin
            if (int_ack) begin
                m_asking  = 0;
                m_serving = 1;
            end else begin
                w = lowest(np & ne);
                if (w < 0) m_asking = 0;
                else begin
                    m_id  = w;
                    m_vec = 8'(int'(m_vbase) + w * 4);
                end
            end
        end else if (m_serving) begin
            if (wr && off == 4) m_serving = 0;
        end else begin
            w = lowest(m_pend & m_en);
            if (w >= 0) begin
                m_asking = 1;
                m_id     = w;
                m_vec    = 8'(int'(m_vbase) + w * 4);
            end
        end
        if (wr && off == 2) m_vbase = w_data;
        if (wr && off == 5) m_mode = w_data & mask;
        m_en   = ne;
        m_pend = np;
        m_prev = 8'(irq_src);
    endtask

    task automatic compare();
        chk("int_req", 8'(int_req), 8'(m_asking));
        chk("int_en", int_en, m_serving ? 8'h00 : 8'h01);
        chk("int_vec", int_vec, m_vec);
        chk("hit", 8'(hit), 8'(in_win(addr)));
        chk("r_data", r_data, model_read(addr));
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare();
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        addr = a; w_data = d; w_en = 1'b1;
        tick();
        w_en = 1'b0;
    endtask

    task automatic rd(input string name, input logic [7:0] a, input logic [7:0] exp);
        addr = a; w_en = 1'b0;
        #1;
        chk(name, r_data, exp);
    endtask

    initial begin
        reset_n = 1'b0; addr = 8'h00; w_data = 8'h00; w_en = 1'b0;
        irq_src = '0; int_ack = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // Single edge source on id 0.
        wr(BASE + 5, 8'h0F); wr(BASE + 0, 8'h01); wr(BASE + 2, 8'h80);
        irq_src = 4'b0001; tick();
        chk("edge_req_k", 8'(int_req), 8'h00);
        rd("edge_pending", BASE + 1, 8'h01);
        irq_src = 4'b0000; tick();
        chk("edge_req_k1", 8'(int_req), 8'h01);
        chk("edge_vec", int_vec, 8'h80);
        rd("edge_cause", BASE + 3, 8'h80);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        chk("ack_int_en", int_en, 8'h00);
        rd("ack_pending", BASE + 1, 8'h00);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        chk("ack_in_service", int_en, 8'h00);
        wr(BASE + 4, 8'h00);
        chk("eoi_int_en", int_en, 8'h01);
        wr(BASE + 4, 8'h00);
        chk("eoi_idle_req", 8'(int_req), 8'h00);

        // Latch while disabled; W1C of bits above N_SRC is ignored.
        irq_src = 4'b0100; tick(); irq_src = 4'b0000;
        wr(BASE + 1, 8'hF0);
        rd("w1c_high", BASE + 1, 8'h04);
        wr(BASE + 1, 8'h04);
        rd("w1c_clear", BASE + 1, 8'h00);

        // Priority and vector re-evaluation.
        wr(BASE + 0, 8'h0F);
        irq_src = 4'b1010; tick(); tick();
        chk("prio_vec1", int_vec, 8'h84);
        irq_src = 4'b1011; tick(); irq_src = 4'b0000;
        chk("prio_vec0", int_vec, 8'h80);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        rd("prio_cause0", BASE + 3, 8'h80);
        wr(BASE + 4, 8'h00); tick();
        chk("prio_next_req", 8'(int_req), 8'h01);
        chk("prio_next_vec", int_vec, 8'h84);

        // Withdrawal, then withdrawal racing an ack.
        wr(BASE + 0, 8'h00);
        chk("withdraw_req", 8'(int_req), 8'h00);
        wr(BASE + 0, 8'h0F); tick();
        addr = BASE + 0; w_data = 8'h00; w_en = 1'b1; int_ack = 1'b1;
        tick();
        w_en = 1'b0; int_ack = 1'b0;
        chk("race_int_en", int_en, 8'h00);
        rd("race_cause", BASE + 3, 8'h81);

        // Reset mid-service.
        reset_n = 1'b0; tick(); tick(); reset_n = 1'b1;
        chk("rst_req", 8'(int_req), 8'h00);
        chk("rst_en", int_en, 8'h01);
        for (int i = 0; i < 6; i++) rd("rst_read", 8'(int'(BASE) + i), 8'h00);

        // Level mode source held high.
        wr(BASE + 0, 8'h04); wr(BASE + 2, 8'h80);
        irq_src = 4'b0100; tick(); tick();
        rd("level_cause", BASE + 3, 8'h82);
        chk("level_vec", int_vec, 8'h88);
        wr(BASE + 1, 8'h04);
        rd("level_held", BASE + 1, 8'h04);
        irq_src = 4'b0000;
        wr(BASE + 1, 8'h04);
        rd("level_clear", BASE + 1, 8'h00);
        chk("level_req_drop", 8'(int_req), 8'h00);

        addr = 8'd239; #1; chk("hit_239", 8'(hit), 8'h00);
        addr = 8'd246; #1; chk("hit_246", 8'(hit), 8'h00);
        addr = 8'd245; #1; chk("hit_245", 8'(hit), 8'h01);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            reset_n = ($urandom_range(0, 299) != 0);
            w_en    = ($urandom_range(0, 3) == 0);
            addr    = 8'(int'(BASE) - 2 + int'($urandom_range(0, 9)));
            w_data  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) irq_src = N'($urandom);
            int_ack = ($urandom_range(0, 4) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
